hilo_muldiv_unit: RTL and testbench



---
 rtl/hilo_muldiv_unit_if.sv | 26 ++
 rtl/hilo_muldiv_unit.sv | 157 +++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_unit_if.sv
// Operand, command and result bundle between the execute stage and the HI/LO multiply/divide unit.
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] Read_data1;
    logic [WIDTH-1:0] Read_data2;
    logic [1:0]       MD_op;
    logic             start;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output Read_data1, Read_data2, MD_op, start, mthi, mtlo,
        input  HI, LO, busy, done, div_zero
    );

    modport slave (
        input  Read_data1, Read_data2, MD_op, start, mthi, mtlo,
        output HI, LO, busy, done, div_zero
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair; one bit per cycle on magnitudes, sign fixed at the end.
// Define MULDIV_FASTZERO_EN to let trivially-zero results skip the iteration phase.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    hilo_muldiv_unit_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t             state_reg;
    logic [1:0]         op_reg;
    logic [WIDTH-1:0]   operand_reg;
    logic [WIDTH-1:0]   shift_reg;
    logic [WIDTH-1:0]   orig_a_reg;
    logic [WIDTH-1:0]   rem_reg;
    logic [WIDTH-1:0]   quo_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [CW-1:0]      cnt_reg;
    logic               neg_q_reg;
    logic               neg_r_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               div_zero_reg;

    // Signed ops work on magnitudes; the most negative value maps to 2^(WIDTH-1) as unsigned.
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    assign sign_a = ~bus.MD_op[0] & bus.Read_data1[WIDTH-1];
    assign sign_b = ~bus.MD_op[0] & bus.Read_data2[WIDTH-1];
    assign mag_a  = sign_a ? -bus.Read_data1 : bus.Read_data1;
    assign mag_b  = sign_b ? -bus.Read_data2 : bus.Read_data2;

    // shift_reg feeds one operand bit per cycle MSB-first; operand_reg holds the other operand.
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     trial;
    logic               fits;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
    assign acc_next = {acc_reg[2*WIDTH-2:0], 1'b0}
                    + (shift_reg[WIDTH-1] ? {{WIDTH{1'b0}}, operand_reg} : '0);
    assign trial    = {rem_reg, shift_reg[WIDTH-1]};
    assign fits     = (trial >= {1'b0, operand_reg});
    assign rem_next = fits ? (trial[WIDTH-1:0] - operand_reg) : trial[WIDTH-1:0];
    assign quo_next = {quo_reg[WIDTH-2:0], fits};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               is_div_zero;
    assign prod_fix    = neg_q_reg ? -acc_reg : acc_reg;
    assign quo_fix     = neg_q_reg ? -quo_reg : quo_reg;
    assign rem_fix     = neg_r_reg ? -rem_reg : rem_reg;
    assign is_div_zero = (operand_reg == '0);

`ifdef MULDIV_FASTZERO_EN
    logic fast_zero;
    assign fast_zero = bus.MD_op[1]
                     ? ((bus.Read_data1 == '0) && (bus.Read_data2 != '0))
                     : ((bus.Read_data1 == '0) || (bus.Read_data2 == '0));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            op_reg       <= '0;
            operand_reg  <= '0;
            shift_reg    <= '0;
            orig_a_reg   <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        op_reg     <= bus.MD_op;
                        neg_q_reg  <= sign_a ^ sign_b;
                        neg_r_reg  <= sign_a;
                        orig_a_reg <= bus.Read_data1;
                        if (bus.MD_op[1]) begin
                            operand_reg <= mag_b;
                            shift_reg   <= mag_a;
                        end else begin
                            operand_reg <= mag_a;
                            shift_reg   <= mag_b;
                        end
                        acc_reg  <= '0;
                        rem_reg  <= '0;
                        quo_reg  <= '0;
                        cnt_reg  <= '0;
                        busy_reg <= 1'b1;
`ifdef MULDIV_FASTZERO_EN
                        state_reg <= fast_zero ? FINISH : RUN;
`else
                        state_reg <= RUN;
`endif
                    end else begin
                        if (bus.mthi) hi_reg <= bus.Read_data1;
                        if (bus.mtlo) lo_reg <= bus.Read_data1;
                    end
                end
                RUN: begin
                    if (op_reg[1]) begin
                        rem_reg <= rem_next;
                        quo_reg <= quo_next;
                    end else begin
                        acc_reg <= acc_next;
                    end
                    shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (cnt_reg == CW'(WIDTH - 1)) state_reg <= FINISH;
                end
                FINISH: begin
                    if (!op_reg[1]) begin
                        hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_reg <= prod_fix[WIDTH-1:0];
                    end else if (is_div_zero) begin
                        hi_reg       <= orig_a_reg;
                        lo_reg       <= '1;
                        div_zero_reg <= 1'b1;
                    end else begin
                        hi_reg       <= rem_fix;
                        lo_reg       <= quo_fix;
                        div_zero_reg <= 1'b0;
                    end
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.HI       = hi_reg;
    assign bus.LO       = lo_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.div_zero = div_zero_reg;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed and random checks of hilo_muldiv_unit against a plain-arithmetic HI/LO model.
module tb_hilo_muldiv_unit;
    localparam int W = 32;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    logic [W-1:0] hi_m;
    logic [W-1:0] lo_m;
    logic         dz_m;

    hilo_muldiv_unit_if #(.WIDTH(W)) bus ();

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin
                p  = 64'(sa * sb);
                hi = p[63:32];
                lo = p[31:0];
            end
            2'b01: begin
                p  = {32'b0, a} * {32'b0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            default: begin
                if (b == '0) begin
                    hi = a;
                    lo = '1;
                end else if (op == 2'b10) begin
                    p  = 64'(sa / sb);
                    lo = p[31:0];
                    p  = 64'(sa % sb);
                    hi = p[31:0];
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    function automatic logic [W-1:0] rnd32();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return '1;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one op; optionally pulse a stray start or mtlo at a given edge, or assert mthi with start.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int pulse_at, input int mtlo_at, input bit with_mthi);
        logic [W-1:0] eh;
        logic [W-1:0] el;
        int           lat;
        int           done_edge;
        model(op, a, b, eh, el);
        lat = W + 1;
`ifdef MULDIV_FASTZERO_EN
        if ((op[1] && a == '0 && b != '0) || (!op[1] && (a == '0 || b == '0))) lat = 1;
`endif
        bus.MD_op      = op;
        bus.Read_data1 = a;
        bus.Read_data2 = b;
        bus.start      = 1'b1;
        bus.mthi       = with_mthi;
        tick();
        bus.start      = 1'b0;
        bus.mthi       = 1'b0;
        bus.Read_data1 = $urandom;
        bus.Read_data2 = $urandom;
        bus.MD_op      = 2'($urandom);
        done_edge = -1;
        for (int k = 1; k <= lat + 2 && done_edge < 0; k++) begin
            if (k == pulse_at) bus.start = 1'b1;
            if (k == mtlo_at) bus.mtlo = 1'b1;
            tick();
            bus.start = 1'b0;
            bus.mtlo  = 1'b0;
            if (bus.done === 1'b1) begin
                done_edge = k;
            end else begin
                check("busy_during_run", 64'(bus.busy), 64'(1));
                check("hi_hold", 64'(bus.HI), 64'(hi_m));
                check("lo_hold", 64'(bus.LO), 64'(lo_m));
            end
        end
        hi_m = eh;
        lo_m = el;
        if (op[1]) dz_m = (b == '0);
        check("latency", 64'(done_edge), 64'(lat));
        check("busy_at_done", 64'(bus.busy), 64'(0));
        check("hi_result", 64'(bus.HI), 64'(hi_m));
        check("lo_result", 64'(bus.LO), 64'(lo_m));
        check("div_zero", 64'(bus.div_zero), 64'(dz_m));
        $display("op=%0d a=%h b=%h -> HI=%h LO=%h dz=%0b done_edge=%0d",
                 op, a, b, bus.HI, bus.LO, bus.div_zero, done_edge);
    endtask

    initial begin
        int done_seen;
        errors = 0;
        checks = 0;
        hi_m = '0;
        lo_m = '0;
        dz_m = 1'b0;
        reset          = 1'b1;
        bus.Read_data1 = '0;
        bus.Read_data2 = '0;
        bus.MD_op      = '0;
        bus.start      = 1'b0;
        bus.mthi       = 1'b0;
        bus.mtlo       = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_hi", 64'(bus.HI), 64'(0));
        check("rst_lo", 64'(bus.LO), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_dz", 64'(bus.div_zero), 64'(0));

        // mthi, then mthi+mtlo together
        bus.Read_data1 = 32'h1234;
        bus.mthi = 1'b1;
        tick();
        bus.mthi = 1'b0;
        hi_m = 32'h1234;
        check("mthi", 64'(bus.HI), 64'(hi_m));
        check("mthi_lo_untouched", 64'(bus.LO), 64'(lo_m));
        bus.Read_data1 = 32'hCAFE_0055;
        bus.mthi = 1'b1;
        bus.mtlo = 1'b1;
        tick();
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        hi_m = 32'hCAFE_0055;
        lo_m = 32'hCAFE_0055;
        check("mthi_both", 64'(bus.HI), 64'(hi_m));
        check("mtlo_both", 64'(bus.LO), 64'(lo_m));
        $display("mthi/mtlo -> HI=%h LO=%h", bus.HI, bus.LO);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 1'b0);
        check("multu_hi_const", 64'(bus.HI), 64'h0000_0000_FFFF_FFFE);
        check("multu_lo_const", 64'(bus.LO), 64'h0000_0000_0000_0001);
        tick();
        check("done_one_cycle", 64'(bus.done), 64'(0));

        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, -1, -1, 1'b0);
        check("mult_neg_hi", 64'(bus.HI), 64'h0000_0000_FFFF_FFFF);
        check("mult_neg_lo", 64'(bus.LO), 64'h0000_0000_FFFF_FFEB);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, -1, -1, 1'b0);
        check("mult_min_hi", 64'(bus.HI), 64'h0000_0000_4000_0000);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, -1, 1'b0);
        check("div_neg_lo", 64'(bus.LO), 64'h0000_0000_FFFF_FFFD);
        check("div_neg_hi", 64'(bus.HI), 64'h0000_0000_FFFF_FFFF);
        run_op(2'b11, 32'd100, 32'd7, -1, -1, 1'b0);
        check("divu_lo", 64'(bus.LO), 64'd14);
        check("divu_hi", 64'(bus.HI), 64'd2);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 1'b0);
        check("div_wrap_lo", 64'(bus.LO), 64'h0000_0000_8000_0000);
        run_op(2'b10, 32'd5, 32'd0, -1, -1, 1'b0);
        check("div0_dz", 64'(bus.div_zero), 64'(1));
        run_op(2'b00, 32'd6, 32'd7, -1, -1, 1'b0);
        check("mult_keeps_dz", 64'(bus.div_zero), 64'(1));
        run_op(2'b11, 32'd9, 32'd3, -1, -1, 1'b0);
        check("dz_cleared", 64'(bus.div_zero), 64'(0));

        run_op(2'b01, 32'd3, 32'd4, 5, -1, 1'b0);
        check("start_ignored_lo", 64'(bus.LO), 64'd12);
        run_op(2'b11, 32'd1000, 32'd33, -1, 10, 1'b0);
        run_op(2'b00, 32'hFFFF_FF00, 32'd3, -1, -1, 1'b1);
        run_op(2'b01, 32'd0, 32'd5, -1, -1, 1'b0);
        run_op(2'b10, 32'd0, 32'd3, -1, -1, 1'b0);
        run_op(2'b10, 32'd0, 32'd0, -1, -1, 1'b0);
        run_op(2'b01, 32'd123, 32'd456, -1, -1, 1'b0);

        // Reset in the middle of a DIVU
        bus.MD_op      = 2'b11;
        bus.Read_data1 = 32'd77;
        bus.Read_data2 = 32'd5;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hi_m = '0;
        lo_m = '0;
        dz_m = 1'b0;
        check("midrst_busy", 64'(bus.busy), 64'(0));
        check("midrst_hi", 64'(bus.HI), 64'(0));
        check("midrst_lo", 64'(bus.LO), 64'(0));
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.done === 1'b1) done_seen++;
        end
        check("midrst_no_done", 64'(done_seen), 64'(0));
        $display("mid-op reset -> HI=%h LO=%h busy=%0b", bus.HI, bus.LO, bus.busy);
        run_op(2'b11, 32'd77, 32'd5, -1, -1, 1'b0);

        for (int n = 0; n < 24; n++) begin
            run_op(2'($urandom_range(0, 3)), rnd32(), rnd32(), -1, -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
